// File: rtl/fp_round_if.sv
// ---------------------------------------------------------------------------
// fp_round_if
//   Bundles the operand-in and result-out handshakes of the rounding
//   sequencer.
//
//   Handshake semantics (both channels): a transfer happens on a rising
//   clock edge where valid and ready are both high. The producer holds
//   valid and its payload stable until that edge. ready may be
//   asserted independently of valid.
//
//   Operand channel  : in_valid, in_ready, in_sign, in_exp, in_sig, rnd_mode
//   Result channel   : out_valid, out_ready, out_sign, out_exp, out_sig,
//                      out_ovf, out_inexact
//   Modports         : master = operand producer / result consumer
//                      slave  = the sequencer
// ---------------------------------------------------------------------------
interface fp_round_if #(
   parameter int EW = 11,
   parameter int SW = 53
);
   localparam int W = SW + 2;

   logic          in_valid;
   logic          in_ready;
   logic          in_sign;
   logic [EW-1:0] in_exp;
   logic [W-1:0]  in_sig;
   logic [1:0]    rnd_mode;

   logic          out_valid;
   logic          out_ready;
   logic          out_sign;
   logic [EW-1:0] out_exp;
   logic [SW-1:0] out_sig;
   logic          out_ovf;
   logic          out_inexact;

   modport master (
      output in_valid, in_sign, in_exp, in_sig, rnd_mode, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_sig, out_ovf,
             out_inexact
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_sig, rnd_mode, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_sig, out_ovf,
             out_inexact
   );
endinterface

// File: rtl/fp_round_seq.sv
// ---------------------------------------------------------------------------
// fp_round_seq
//   Multi-cycle rounding sequencer for the FPU result path. Takes one
//   unrounded result (sign, biased exponent, significand with guard and
//   sticky), normalizes it one left shift per cycle, rounds it in the
//   selected IEEE mode, fixes up a rounding carry-out and presents the
//   packed result with overflow/inexact flags.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     flush      synchronous abort, drops the operation in flight
//     bus        fp_round_if.slave (operand and result handshakes)
//     dbg_state  current FSM state (encoding of state_t)
// ---------------------------------------------------------------------------
module fp_round_seq #(
   parameter int EW = 11,
   parameter int SW = 53
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   fp_round_if.slave  bus,
   output logic [2:0] dbg_state
);
   localparam int W = SW + 2;

   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RTZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;

   localparam logic [EW-1:0] EXP_INF    = '1;
   localparam logic [EW-1:0] EXP_MAXFIN = {{(EW-1){1'b1}}, 1'b0};
   localparam logic [EW-1:0] EXP_ONE    = EW'(1);
   localparam logic [SW-1:0] SIG_ONES   = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_NORM  = 3'd1,
      S_ROUND = 3'd2,
      S_POST  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state_r, state_n;

   // Working registers
   logic          sign_r;
   logic [EW-1:0] exp_r;
   logic [W-1:0]  sig_r;
   logic [1:0]    mode_r;
   logic [SW:0]   f2_r;
   logic          inexact_r;

   // Output registers; they only change when a result is produced
   logic          out_sign_r;
   logic [EW-1:0] out_exp_r;
   logic [SW-1:0] out_sig_r;
   logic          out_ovf_r;
   logic          out_inexact_r;

   // Decodes
   logic in_special;
   logic accept;
   logic norm_stop;

   assign in_special = (bus.in_exp == EXP_INF);
   assign accept     = bus.in_valid && (state_r == S_IDLE);
   // Normalization stops at a leading one or when the exponent can go no
   // lower without leaving the subnormal range.
   assign norm_stop  = sig_r[W-1] || (exp_r <= EXP_ONE);

   // Rounding increment
   logic rnd_lsb, rnd_g, rnd_s, rnd_inc;

   assign rnd_lsb = sig_r[2];
   assign rnd_g   = sig_r[1];
   assign rnd_s   = sig_r[0];

   always_comb begin
      rnd_inc = 1'b0;
      unique case (mode_r)
         RM_RNE: rnd_inc = rnd_g & (rnd_s | rnd_lsb);
         RM_RTZ: rnd_inc = 1'b0;
         RM_RUP: rnd_inc = ~sign_r & (rnd_g | rnd_s);
         RM_RDN: rnd_inc =  sign_r & (rnd_g | rnd_s);
         default: rnd_inc = 1'b0;
      endcase
   end

   // Post-normalization and overflow saturation
   logic          sig_ovf;
   logic [SW-1:0] f3;
   logic [EW-1:0] post_exp;
   logic          post_ovf;
   logic          ovf_to_inf;
   logic [EW-1:0] res_exp;
   logic [SW-1:0] res_sig;
   logic          res_inexact;

   always_comb begin
      sig_ovf     = f2_r[SW];
      f3          = sig_ovf ? f2_r[SW:1] : f2_r[SW-1:0];
      // exp_r is at most all-ones minus one here, so the +1 cannot wrap.
      post_exp    = exp_r + {{(EW-1){1'b0}}, sig_ovf};
      if (!f3[SW-1]) begin
         post_exp = '0;
      end
      post_ovf    = (post_exp == EXP_INF);

      ovf_to_inf = 1'b1;
      unique case (mode_r)
         RM_RNE: ovf_to_inf = 1'b1;
         RM_RTZ: ovf_to_inf = 1'b0;
         RM_RUP: ovf_to_inf = ~sign_r;
         RM_RDN: ovf_to_inf = sign_r;
         default: ovf_to_inf = 1'b1;
      endcase

      res_exp     = post_exp;
      res_sig     = f3;
      res_inexact = inexact_r;
      if (post_ovf) begin
         res_inexact = 1'b1;
         if (ovf_to_inf) begin
            res_exp = EXP_INF;
            res_sig = '0;
         end else begin
            res_exp = EXP_MAXFIN;
            res_sig = SIG_ONES;
         end
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // FSM: next state; flush overrides every transition
   always_comb begin
      state_n = state_r;
      unique case (state_r)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_n = in_special ? S_DONE : S_NORM;
            end
         end
         S_NORM: begin
            if ((sig_r == '0) || norm_stop) begin
               state_n = S_ROUND;
            end
         end
         S_ROUND: state_n = S_POST;
         S_POST:  state_n = S_DONE;
         S_DONE: begin
            if (bus.out_ready) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
      if (flush) begin
         state_n = S_IDLE;
      end
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_r        <= 1'b0;
         exp_r         <= '0;
         sig_r         <= '0;
         mode_r        <= RM_RNE;
         f2_r          <= '0;
         inexact_r     <= 1'b0;
         out_sign_r    <= 1'b0;
         out_exp_r     <= '0;
         out_sig_r     <= '0;
         out_ovf_r     <= 1'b0;
         out_inexact_r <= 1'b0;
      end else if (!flush) begin
         unique case (state_r)
            S_IDLE: begin
               if (accept) begin
                  sign_r <= bus.in_sign;
                  exp_r  <= bus.in_exp;
                  sig_r  <= bus.in_sig;
                  mode_r <= bus.rnd_mode;
                  // Inf/NaN pass straight through, unrounded and unflagged.
                  if (in_special) begin
                     out_sign_r    <= bus.in_sign;
                     out_exp_r     <= bus.in_exp;
                     out_sig_r     <= bus.in_sig[W-1:2];
                     out_ovf_r     <= 1'b0;
                     out_inexact_r <= 1'b0;
                  end
               end
            end
            S_NORM: begin
               if (sig_r == '0) begin
                  exp_r <= '0;
               end else if (!norm_stop) begin
                  sig_r <= {sig_r[W-2:0], 1'b0};
                  exp_r <= exp_r - EXP_ONE;
               end
            end
            S_ROUND: begin
               f2_r      <= {1'b0, sig_r[W-1:2]} + {{SW{1'b0}}, rnd_inc};
               inexact_r <= rnd_g | rnd_s;
            end
            S_POST: begin
               out_sign_r    <= sign_r;
               out_exp_r     <= res_exp;
               out_sig_r     <= res_sig;
               out_ovf_r     <= post_ovf;
               out_inexact_r <= res_inexact;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready    = (state_r == S_IDLE);
   assign bus.out_valid   = (state_r == S_DONE);
   assign bus.out_sign    = out_sign_r;
   assign bus.out_exp     = out_exp_r;
   assign bus.out_sig     = out_sig_r;
   assign bus.out_ovf     = out_ovf_r;
   assign bus.out_inexact = out_inexact_r;
   assign dbg_state       = state_r;

endmodule

// File: doc/fp_round_seq.md
# fp_round_seq

Multi-cycle sequencer for the FPU rounding path, double precision by default. Accepts one unrounded result (sign, biased exponent, wide significand with guard/sticky) through a valid/ready handshake. Normalizes it with one left shift per cycle, applies the selected IEEE rounding mode, then performs the post-normalization step (significand overflow → shift right, exponent +1). Presents the packed result, with overflow and inexact flags, through a second valid/ready handshake. It sits between the add/mul significand datapath and the result writeback.

## Interface
- EW, 11, exponent width (biased)
- SW, 53, significand width including hidden bit; input significand width W = SW+2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort: any state → IDLE next edge, operation dropped, no out_valid
- in_valid  in  1  operand present
- in_ready  out  1  = (state==IDLE); combinational from state
- in_sign  in  1  result sign
- in_exp  in  EW  biased exponent
- in_sig  in  W  bits [W-1:2] significand (MSB weight 1.0 when normalized), bit 1 guard, bit 0 sticky
- rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (−inf); sampled at accept
- out_valid  out  1  result held valid (state==DONE)
- out_ready  in  1  consumer accepts
- out_sign  out  1
- out_exp  out  EW
- out_sig  out  SW  rounded significand including hidden bit
- out_ovf  out  1  exponent overflow occurred
- out_inexact  out  1  guard|sticky nonzero after normalization

## Operation
- States: IDLE, NORM, ROUND, POST, DONE.
- IDLE: on in_valid&in_ready, register sign/exp/sig/mode. Special input (in_exp all ones) → DONE with out_sig=in_sig[W-1:2], exp unchanged, flags 0. Otherwise → NORM.
- NORM, each cycle:
  - If sig==0: exp:=0, → ROUND.
  - Else if sig[W-1]==1 or exp<=1: → ROUND.
  - Else: sig:=sig<<1 (zero in at bit 0), exp:=exp−1, stay.
- ROUND: lsb=sig[2], g=sig[1], s=sig[0].
  - inc: RNE g&(s|lsb); RTZ 0; RUP ~sign&(g|s); RDN sign&(g|s).
  - f2 (SW+1 bits) := {1'b0, sig[W-1:2]} + inc; inexact := g|s; → POST.
- POST:
  - sigovf = f2[SW]. If set: f3 := f2[SW:1], exp+1; else f3 := f2[SW-1:0].
  - If f3[SW-1]==0: out_exp:=0 (subnormal/zero).
  - If the resulting exp is all ones (overflow): out_ovf=1, inexact=1.
    - RNE → inf (exp all ones, sig 0).
    - RTZ → max finite (exp 2^EW−2, sig all ones).
    - RUP → inf if +, max finite if −.
    - RDN → inf if −, max finite if +.
  - → DONE.
- DONE: outputs stable while out_ready=0; on out_ready → IDLE.
- Reset: all outputs 0 except in_ready=1; state IDLE. Asserting rst_n mid-operation abandons it immediately, asynchronously.
- flush takes priority over every transition, including DONE&out_ready.

## Timing
- Accept edge → NORM. With k left shifts, out_valid rises after k+3 further edges: k+1 NORM, 1 ROUND, 1 POST.
- Special input: out_valid after 1 edge.
- k ≤ min(W−1, in_exp−1); maximum latency 57 edges.
- Earliest next accept is the edge after the DONE→IDLE edge. No overlap; throughput one op per k+5 cycles with out_ready=1.
- Output registers update only on the POST→DONE edge (or the IDLE→DONE edge for specials). They hold between operations.

## Test plan
- Exact normalized: in_exp=0x3FF, in_sig=0x40_0000_0000_0000, RNE → out_valid 3 edges after accept, out_exp=0x3FF, out_sig=0x10_0000_0000_0000, inexact=0, ovf=0.
- Normalize: in_exp=0x3FF, in_sig=1<<50 → 4 shifts, out_valid after 7 edges, out_exp=0x3FB, out_sig=0x10_0000_0000_0000.
- Round carry: in_exp=0x400, in_sig=0x7F_FFFF_FFFF_FFFF.
  - RNE → out_exp=0x401, out_sig=0x10_0000_0000_0000, inexact=1.
  - RTZ → out_exp=0x400, out_sig=0x1F_FFFF_FFFF_FFFF.
- Overflow: in_exp=0x7FE, in_sig=0x7F_FFFF_FFFF_FFFF.
  - RNE → exp=0x7FF, sig=0, ovf=1.
  - RTZ → exp=0x7FE, sig=0x1F_FFFF_FFFF_FFFF, ovf=1.
  - RDN with sign=0 → same result as RTZ.
- Subnormal/zero: in_exp=1, in_sig=1<<52 → 0 shifts, out_exp=0, out_sig=1<<50. in_sig=0 → out_exp=0, out_sig=0, inexact=0.
- Handshake/abort:
  - out_ready=0 for 5 cycles → outputs and out_valid stable, in_ready=0.
  - flush during NORM → IDLE next edge, no out_valid.
  - rst_n low during NORM → in_ready=1 and outputs 0 without waiting for a clock edge.
